// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : Stall / flush generator for the five-stage pipeline.       |
// |               Keeps shadow copies of the rd tags in flight in EX and MEM,|
// |               detects dependencies that forwarding cannot cover, holds   |
// |               PC and IF/ID, bubbles ID/EX, squashes wrong-path fetches   |
// |               and counts stall and flush cycles (saturating).            |
// | Ports       : clk, rst_n (async, active low)                             |
// |               ifid_rs1addr/rs2addr/rs1used/rs2used/isbranch : ID sources |
// |               id_rdaddr/id_rdwren/id_memread : ID destination info       |
// |               br_redirect : taken branch/jump resolved in ID             |
// |               freeze      : whole pipeline held by memory wait           |
// |               pc_en, ifid_en, idex_bubble, ifid_flush : pipeline control |
// |               stall_cnt, flush_cnt : saturating event counters           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       ifid_rs1addr,
   input  logic [4:0]       ifid_rs2addr,
   input  logic             ifid_rs1used,
   input  logic             ifid_rs2used,
   input  logic             ifid_isbranch,
   input  logic [4:0]       id_rdaddr,
   input  logic             id_rdwren,
   input  logic             id_memread,
   input  logic             br_redirect,
   input  logic             freeze,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   // Shadow copies of the ID/EX and EX/MEM destination tags
   logic [4:0]       ex_rd_q,   ex_rd_d;
   logic             ex_wren_q, ex_wren_d;
   logic             ex_load_q, ex_load_d;
   logic [4:0]       mem_rd_q,   mem_rd_d;
   logic             mem_wren_q, mem_wren_d;
   logic             mem_load_q, mem_load_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic w_rs1_hit_ex, w_rs2_hit_ex, w_rs1_hit_mem, w_rs2_hit_mem;
   logic w_load_use, w_br_stall, w_stall;

   always_comb begin
      w_rs1_hit_ex  = ifid_rs1used & ex_wren_q  & (ifid_rs1addr == ex_rd_q);
      w_rs2_hit_ex  = ifid_rs2used & ex_wren_q  & (ifid_rs2addr == ex_rd_q);
      w_rs1_hit_mem = ifid_rs1used & mem_wren_q & (ifid_rs1addr == mem_rd_q);
      w_rs2_hit_mem = ifid_rs2used & mem_wren_q & (ifid_rs2addr == mem_rd_q);
      w_load_use    = (w_rs1_hit_ex | w_rs2_hit_ex) & ex_load_q;
      // Branch operands are compared in ID, so a load result in MEM is
      // still too late; an ALU result in EX/MEM is forwarded.
      w_br_stall    = ifid_isbranch &
                      (((w_rs1_hit_ex  | w_rs2_hit_ex)  & ex_load_q) |
                       ((w_rs1_hit_mem | w_rs2_hit_mem) & mem_load_q));
      w_stall       = w_load_use | w_br_stall;
   end

   // Pipeline control outputs
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (!freeze) begin
         pc_en       = ~w_stall;
         ifid_en     = ~w_stall;
         idex_bubble = w_stall;
         // A redirect seen during a stall uses stale operands; ID will
         // re-present it once the stall clears.
         ifid_flush  = br_redirect & ~w_stall;
      end
   end

   // Next-state for shadows and counters
   always_comb begin
      ex_rd_d     = ex_rd_q;
      ex_wren_d   = ex_wren_q;
      ex_load_d   = ex_load_q;
      mem_rd_d    = mem_rd_q;
      mem_wren_d  = mem_wren_q;
      mem_load_d  = mem_load_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!freeze) begin
         mem_rd_d   = ex_rd_q;
         mem_wren_d = ex_wren_q;
         mem_load_d = ex_load_q;
         if (w_stall) begin
            ex_rd_d   = 5'd0;
            ex_wren_d = 1'b0;
            ex_load_d = 1'b0;
         end else begin
            ex_rd_d   = id_rdaddr;
            // x0 writes are discarded so they can never create a hazard
            ex_wren_d = id_rdwren & (id_rdaddr != 5'd0);
            ex_load_d = id_memread;
         end
         if (w_stall && (stall_cnt_q != c_cnt_max)) begin
            stall_cnt_d = stall_cnt_q + c_cnt_one;
         end
      end
      if (ifid_flush && (flush_cnt_q != c_cnt_max)) begin
         flush_cnt_d = flush_cnt_q + c_cnt_one;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd_q     <= 5'd0;
         ex_wren_q   <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_rd_q    <= 5'd0;
         mem_wren_q  <= 1'b0;
         mem_load_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_rd_q     <= ex_rd_d;
         ex_wren_q   <= ex_wren_d;
         ex_load_q   <= ex_load_d;
         mem_rd_q    <= mem_rd_d;
         mem_wren_q  <= mem_wren_d;
         mem_load_q  <= mem_load_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Scoreboard bench for hazard_ctrl. A reference model based |
// |               on producer distance / result readiness predicts outputs, |
// |               pushes them to a queue, and a monitor compares them.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

   localparam int CNT_W = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       ifid_rs1addr = '0, ifid_rs2addr = '0, id_rdaddr = '0;
   logic             ifid_rs1used = 0, ifid_rs2used = 0, ifid_isbranch = 0;
   logic             id_rdwren = 0, id_memread = 0, br_redirect = 0, freeze = 0;
   logic             pc_en, ifid_en, idex_bubble, ifid_flush;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifid_rs1addr(ifid_rs1addr), .ifid_rs2addr(ifid_rs2addr),
      .ifid_rs1used(ifid_rs1used), .ifid_rs2used(ifid_rs2used),
      .ifid_isbranch(ifid_isbranch),
      .id_rdaddr(id_rdaddr), .id_rdwren(id_rdwren), .id_memread(id_memread),
      .br_redirect(br_redirect), .freeze(freeze),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
      .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      bit u1, u2, br, wr, ld, redir, frz;
   } stim_t;

   typedef struct {
      bit pc, ifen, bub, fl;
      int scnt, fcnt;
   } exp_t;

   typedef struct {
      logic [4:0] rd;
      bit wr, ld;
   } prod_t;

   exp_t  exp_q[$];
   prod_t pipe[1:2];          // index = distance of producer ahead of ID
   int    m_scnt, m_fcnt;
   int    total = 0, bad = 0;
   bit    stim_done = 0;

   function automatic void model_reset();
      for (int d = 1; d <= 2; d++) pipe[d] = '{rd: 5'd0, wr: 0, ld: 0};
      m_scnt = 0;
      m_fcnt = 0;
   endfunction

   // A producer's value reaches an ID consumer once it is far enough ahead:
   // ALU results at distance 1, loads at 2, loads feeding an ID compare at 3.
   function automatic bit model_stall(stim_t s);
      bit st = 0;
      for (int d = 1; d <= 2; d++) begin
         int need;
         if (!pipe[d].wr || pipe[d].rd == 5'd0) continue;
         need = pipe[d].ld ? (s.br ? 3 : 2) : 1;
         if (d < need && ((s.u1 && s.rs1 == pipe[d].rd) ||
                          (s.u2 && s.rs2 == pipe[d].rd))) st = 1;
      end
      return st;
   endfunction

   task automatic step(stim_t s, bit rst_val);
      exp_t e;
      bit   st;
      @(posedge clk);
      #1;
      rst_n         = rst_val;
      ifid_rs1addr  = s.rs1;  ifid_rs2addr = s.rs2;
      ifid_rs1used  = s.u1;   ifid_rs2used = s.u2;
      ifid_isbranch = s.br;   id_rdaddr    = s.rd;
      id_rdwren     = s.wr;   id_memread   = s.ld;
      br_redirect   = s.redir; freeze      = s.frz;
      if (!rst_val) model_reset();
      st = model_stall(s);
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      if (s.frz) begin
         e.pc = 0; e.ifen = 0; e.bub = 0; e.fl = 0;
      end else begin
         e.pc = !st; e.ifen = !st; e.bub = st; e.fl = s.redir && !st;
      end
      exp_q.push_back(e);
      if (rst_val && !s.frz) begin
         if (st && m_scnt < CNT_MAX) m_scnt++;
         if (e.fl && m_fcnt < CNT_MAX) m_fcnt++;
         pipe[2] = pipe[1];
         pipe[1] = st ? '{rd: 5'd0, wr: 0, ld: 0}
                      : '{rd: s.rd, wr: s.wr, ld: s.ld};
      end
   endtask

   function automatic stim_t mk(logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                                bit br, logic [4:0] rd, bit wr, bit ld,
                                bit redir, bit frz);
      stim_t s;
      s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.br = br;
      s.rd = rd; s.wr = wr; s.ld = ld; s.redir = redir; s.frz = frz;
      return s;
   endfunction

   task automatic chk(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_en",       int'(pc_en),       int'(e.pc));
            chk("ifid_en",     int'(ifid_en),     int'(e.ifen));
            chk("idex_bubble", int'(idex_bubble), int'(e.bub));
            chk("ifid_flush",  int'(ifid_flush),  int'(e.fl));
            chk("stall_cnt",   int'(stall_cnt),   e.scnt);
            chk("flush_cnt",   int'(flush_cnt),   e.fcnt);
         end
      end
   end

   initial begin
      stim_t nop, lw5, add65, add5, beq5, lw7, bne7, lw0, addx0, nouse5;
      model_reset();
      nop    = mk(0,0, 0,0, 0, 0,0,0, 0,0);
      lw5    = mk(1,1, 0,0, 0, 5,1,1, 0,0);
      add65  = mk(5,1, 1,1, 0, 6,1,0, 0,0);
      add5   = mk(1,1, 2,1, 0, 5,1,0, 0,0);
      beq5   = mk(5,1, 0,1, 1, 0,0,0, 1,0);
      lw7    = mk(1,1, 0,0, 0, 7,1,1, 0,0);
      bne7   = mk(7,1, 2,1, 1, 0,0,0, 1,0);
      lw0    = mk(1,1, 0,0, 0, 0,1,1, 0,0);
      addx0  = mk(0,1, 0,1, 0, 6,1,0, 0,0);
      nouse5 = mk(5,0, 5,0, 0, 6,1,0, 0,0);

      // Reset state
      step(nop, 0);
      step(nop, 0);
      step(nop, 1);
      // Load-use: one stall
      step(lw5, 1); step(add65, 1); step(add65, 1); step(nop, 1); step(nop, 1);
      // ALU then branch: no stall, one flush
      step(add5, 1); step(beq5, 1); step(nop, 1); step(nop, 1);
      // Load then branch: two stalls then flush
      step(lw7, 1); step(bne7, 1); step(bne7, 1); step(bne7, 1); step(nop, 1);
      // x0 and unused operand
      step(lw0, 1); step(addx0, 1); step(nop, 1);
      step(lw5, 1); step(nouse5, 1); step(nop, 1); step(nop, 1);
      // Freeze across a load-use stall
      step(lw5, 1);
      add65.frz = 1;
      repeat (3) step(add65, 1);
      add65.frz = 0;
      step(add65, 1); step(add65, 1); step(nop, 1); step(nop, 1);
      // Reset during a branch stall
      step(lw7, 1); step(bne7, 1);
      bne7.redir = 0;
      step(bne7, 0); step(bne7, 0);
      step(bne7, 1); step(nop, 1);

      // Randomized traffic on a small register window to force collisions
      for (int i = 0; i < 600; i++) begin
         stim_t s;
         bit    r;
         s = mk(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
                1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                ($urandom_range(0, 7) == 0));
         r = ($urandom_range(0, 149) != 0);
         step(s, r);
      end
      step(nop, 1);
      stim_done = 1;
   end

   initial begin
      int guard = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall and flush generator for the five-stage pipeline; the producer-side companion to the branch/ALU forwarding selectors. It keeps its own shadow copy of the destination-register tags in flight in EX and MEM. It compares them against the source registers of the instruction in ID and decides when forwarding cannot cover a dependency. On those cycles it freezes PC and IF/ID, injects a bubble into ID/EX, squashes the wrong-path fetch on a taken redirect, and counts stall and flush events.

## Interface
- CNT_W, 32, width of the stall and flush event counters

- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ifid_rs1addr  in  5  rs1 of instruction in ID
- ifid_rs2addr  in  5  rs2 of instruction in ID
- ifid_rs1used  in  1  ID instruction reads rs1
- ifid_rs2used  in  1  ID instruction reads rs2
- ifid_isbranch  in  1  ID instruction compares operands in ID (branch, jalr)
- id_rdaddr  in  5  rd of instruction in ID
- id_rdwren  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- br_redirect  in  1  ID resolved a taken branch or jump this cycle
- freeze  in  1  whole pipeline held by memory wait
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  clear IF/ID (squash fetched instruction)
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flush cycles

## Operation
- Shadow registers: ex_{rd,wren,load} for the ID/EX slot and mem_{rd,wren,load} for the EX/MEM slot. wren is stored as id_rdwren & (id_rdaddr != 0), so x0 never creates a hazard.
- Match rule: rsN_hit_X = ifid_rsNused & X_wren & (ifid_rsNaddr == X_rd), for X in {ex, mem} and N in {1, 2}.
- Load-use stall:
  - condition: any rsN_hit_ex with ex_load = 1, for any instruction.
  - result: 1 stall cycle; after it, MEM/WB forwarding covers the dependency.
- Branch stall (ifid_isbranch = 1):
  - condition: rsN_hit_ex with ex_load = 1 (already covered by load-use), or rsN_hit_mem with mem_load = 1, since load data is unavailable to the ID comparator until WB.
  - branch directly after a load: 2 stall cycles.
  - branch after an ALU instruction: 0 stall cycles, covered by EX forwarding.
- stall = load-use | branch stall, combinational.
- Outputs (all combinational from state and inputs):
  - freeze = 1: pc_en = 0, ifid_en = 0, idex_bubble = 0, ifid_flush = 0.
  - otherwise: pc_en = ifid_en = ~stall; idex_bubble = stall; ifid_flush = br_redirect & ~stall.
  - A redirect during a stall is ignored because its operands are not yet valid. It is reasserted once the stall clears.
- Shadow update on the rising edge:
  - freeze = 1: hold all shadow registers.
  - stall = 1: ex_* <= 0 (bubble).
  - otherwise: ex_* <= ID fields.
  - always when not frozen: mem_* <= ex_*.
- Counters:
  - stall_cnt increments on a stall cycle with freeze = 0.
  - flush_cnt increments when ifid_flush = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, rst_n = 0): all shadow registers = 0 and both counters = 0. Outputs follow immediately: pc_en = 1, ifid_en = 1, idex_bubble = 0, ifid_flush = 0.
- Reset released mid-stall: the pipeline restarts with no stall pending.
- Stall decision has zero latency, same cycle as the ID contents. The shadow state reflects a decision on the next edge.
- A freeze that overlaps a stall extends the stall; it does not count extra stall cycles.
- Both rs1 and rs2 hitting counts as a single stall per cycle.

## Test plan
- Load-use: load x5, then add x6,x5,x1 → exactly 1 cycle with pc_en = 0 and idex_bubble = 1; stall_cnt = 1.
- ALU then branch: add x5, then beq x5,x0 → no stall; taken redirect gives ifid_flush = 1 for 1 cycle; flush_cnt = 1.
- Load then branch: lw x7, then bne x7,x2, taken → 2 stall cycles, then ifid_flush = 1 on the third cycle; stall_cnt = 2.
- x0 and unused operands: lw x0 followed by add using x0, and lw x5 followed by an instruction with rs1used = 0 on x5 → no stall.
- Freeze: assert freeze for 3 cycles during a load-use stall → pc_en = 0 throughout, stall_cnt increments only once, shadow registers unchanged.
- Reset mid-stall: pull rst_n low while a branch stall is active → outputs immediately return to pc_en = 1, stall_cnt = 0; no stall after release.
